// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO responder: register offsets and port width.
package gpio_pkg;

  localparam int unsigned GPIO_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BE_W      = 4;

  localparam logic [ADDR_W-1:0] GPIO_LED_OFF   = 4'h0;
  localparam logic [ADDR_W-1:0] GPIO_SW_OFF    = 4'h4;
  localparam logic [ADDR_W-1:0] GPIO_EDGE_OFF  = 4'h8;
  localparam logic [ADDR_W-1:0] GPIO_IRQEN_OFF = 4'hC;

endpackage

// File: rtl/gpio_responder_if.sv
// Peripheral-port access bus between the memory controller and the GPIO block.
interface gpio_responder_if;
  import gpio_pkg::*;

  logic              en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output en, output we, output addr, output be, output wdata,
                  input rdata, input ready);
  modport slave  (input en, input we, input addr, input be, input wdata,
                  output rdata, output ready);
endinterface

// File: rtl/gpio_responder_sw_debounce.sv
// One switch bit: two-flop synchronizer, stability counter, debounced level and
// a combinational toggle strobe that is high on the edge the level flips.
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic toggle_c
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          dout_nxt;

  // Level flips once the synchronized input has disagreed long enough.
  always_comb begin
    cnt_nxt  = '0;
    dout_nxt = dout;
    toggle_c = 1'b0;
    if (sync2 != dout) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout_nxt = ~dout;
        toggle_c = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
    end
  end

endmodule

// File: rtl/gpio_responder.sv
// GPIO responder: LED/SW/EDGE/IRQEN registers behind a single-cycle load/store
// port, with per-bit switch debouncing and a level interrupt.
module gpio_responder
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  gpio_responder_if.slave    bus,
  input  logic [GPIO_W-1:0]  switches,
  output logic [GPIO_W-1:0]  leds,
  output logic               irq
);

  logic [GPIO_W-1:0] sw_deb;
  logic [GPIO_W-1:0] sw_tog_c;
  logic [GPIO_W-1:0] edge_r;
  logic [GPIO_W-1:0] irqen;

  logic [GPIO_W-1:0] leds_nxt;
  logic [GPIO_W-1:0] edge_nxt;
  logic [GPIO_W-1:0] irqen_nxt;
  logic [GPIO_W-1:0] rd_val;
  logic [DATA_W-1:0] rdata_nxt;
  logic [ADDR_W-1:0] word_off;
  logic              wr;
  logic              unused_bus_bits;

  assign unused_bus_bits = ^{bus.addr[1:0], bus.be[BE_W-1:1], bus.wdata[DATA_W-1:GPIO_W]};

  for (genvar i = 0; i < int'(GPIO_W); i++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .din      (switches[i]),
      .dout     (sw_deb[i]),
      .toggle_c (sw_tog_c[i])
    );
  end

  assign word_off = {bus.addr[ADDR_W-1:2], 2'b00};
  assign wr       = bus.en & bus.we & bus.be[0];

  // Read mux, register updates and W1C-vs-set priority (set wins).
  always_comb begin
    rd_val    = '0;
    leds_nxt  = leds;
    irqen_nxt = irqen;
    edge_nxt  = edge_r;
    case (word_off)
      GPIO_LED_OFF:   rd_val = leds;
      GPIO_SW_OFF:    rd_val = sw_deb;
      GPIO_EDGE_OFF:  rd_val = edge_r;
      GPIO_IRQEN_OFF: rd_val = irqen;
      default:        rd_val = '0;
    endcase
    if (wr) begin
      case (word_off)
        GPIO_LED_OFF:   leds_nxt  = bus.wdata[GPIO_W-1:0];
        GPIO_EDGE_OFF:  edge_nxt  = edge_r & ~bus.wdata[GPIO_W-1:0];
        GPIO_IRQEN_OFF: irqen_nxt = bus.wdata[GPIO_W-1:0];
        default:        ;
      endcase
    end
    edge_nxt  = edge_nxt | sw_tog_c;
    rdata_nxt = (bus.en && !bus.we) ? DATA_W'(rd_val) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      leds      <= '0;
      edge_r    <= '0;
      irqen     <= '0;
      irq       <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      leds      <= leds_nxt;
      edge_r    <= edge_nxt;
      irqen     <= irqen_nxt;
      irq       <= |(edge_r & irqen);
      bus.ready <= bus.en;
      bus.rdata <= rdata_nxt;
    end
  end

endmodule
